seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle restoring divider; the inverse arithmetic path to the combinational adder in the ALU datapath.
- Produces quotient and remainder one bit per clock using a shared subtract/restore step.
- Sits beside the ALU, which launches it with a start pulse and collects results on a done pulse.
- Single clock domain. Reset is synchronous and active-high.

Parameters:
width, 8, operand/result bit width (>= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  width  numerator, captured when start accepted
divisor  input  width  denominator, captured when start accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, results valid
quotient  output  width  registered quotient
remainder  output  width  registered remainder
div_by_zero  output  1  registered flag, divisor was 0 for the last operation

Behaviour:
- States: IDLE, RUN, DONE. Reset (clk edge with reset=1) forces IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal count=0. Reset beats every other input.
- IDLE and start=1, divisor!=0, at edge E0:
  - capture operands;
  - working remainder=0, working quotient=dividend, count=0;
  - go to RUN.
- IDLE and start=1, divisor==0, at E0:
  - go directly to DONE;
  - on that edge load quotient={width{1}}, remainder=dividend, div_by_zero=1.
- RUN, each edge (one iteration):
  - shift {rem,quo} left 1;
  - trial = rem - divisor, computed (width+1) bits wide;
  - if trial is non-negative: rem = trial and quo LSB = 1; else restore rem and quo LSB = 0;
  - count++.
- After width iterations (edge E0+width):
  - go to DONE;
  - on that same edge load the output registers quotient/remainder and set div_by_zero=0.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE on the next edge.
- Timing: done is high in the cycle after edge E0+width, or after E0+1 for divide-by-zero.
- busy=1 exactly in RUN (width cycles). done and busy are never high together.
- start is ignored in RUN and DONE; no queuing. Operand inputs are don't-care outside E0.
- Output registers hold their values until the next result load. They do not change during RUN.
- Reset mid-RUN: the operation is abandoned, all outputs go to reset values, and no done pulse occurs.
- Arithmetic: unsigned by default.
  - quotient*divisor + remainder == dividend; remainder < divisor.
  - The internal subtract is width+1 bits, so no overflow is possible.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - operands are two's complement;
  - magnitudes are captured at E0 and the unsigned core runs unchanged;
  - sign fix-up is applied when loading the output registers, so latency is unchanged;
  - quotient truncates toward zero and is negated if the operand signs differ;
  - remainder takes the sign of the dividend;
  - most-negative / -1 gives quotient=most-negative, remainder=0, div_by_zero=0;
  - divide-by-zero gives quotient=-1 (all ones), remainder=dividend.
- Undefined: pure unsigned operation; no sign logic is synthesised.

Test Plan (width=8):
- Reset high for 2 cycles, then low: all outputs 0 → start dividend=100 divisor=7. Required: busy=1 for 8 cycles, done=1 in the 9th cycle after the start edge, quotient=14, remainder=2, div_by_zero=0.
- dividend=255 divisor=1 → quotient=255, remainder=0. Then dividend=3 divisor=10 → quotient=0, remainder=3. Results hold after done drops.
- dividend=5 divisor=0 → done in the cycle after the start edge, busy never high, quotient=8'hFF, remainder=5, div_by_zero=1.
- Assert start again with new operands during RUN and during DONE → both ignored. The first operation's result is unchanged, and the next start is accepted only once back in IDLE.
- reset=1 at RUN iteration 4 → next cycle busy=0, outputs 0, no done pulse. A fresh 200/9 afterwards → quotient=22, remainder=2.
- With SEQ_DIVIDER_SIGNED_EN:
  - -7/2 → quotient=8'hFD (-3), remainder=8'hFF (-1);
  - -128/-1 → quotient=8'h80, remainder=0;
  - latency is still 9 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operands with sign fix-up.
module seq_divider #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int cw = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [cw-1:0]    count;
    logic [width-1:0] rem_w;
    logic [width-1:0] quo_w;
    logic [width-1:0] dvs;
    logic [width:0]   rem_sh;
    logic [width-1:0] diff;
    logic             trial_ok;
    logic [width-1:0] rem_nxt;
    logic [width-1:0] quo_nxt;
    logic [width-1:0] a_mag;
    logic [width-1:0] b_mag;
    logic [width-1:0] q_fix;
    logic [width-1:0] r_fix;
    logic             last_iter;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             q_neg;
    logic             r_neg;

    function automatic logic [width-1:0] magnitude(input logic [width-1:0] v);
        return v[width-1] ? (~v + width'(1)) : v;
    endfunction
`endif

    assign last_iter = (count == cw'(width - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == {width{1'b0}}) ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One subtract/restore iteration. The shifted remainder is width+1 bits; its
    // borrow decision uses the full value, while the kept difference always fits
    // in width bits because it is smaller than the divisor.
    always_comb begin
        rem_sh   = {rem_w, quo_w[width-1]};
        trial_ok = (rem_sh >= {1'b0, dvs});
        diff     = rem_sh[width-1:0] - dvs;
        if (trial_ok) begin
            rem_nxt = diff;
            quo_nxt = {quo_w[width-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[width-1:0];
            quo_nxt = {quo_w[width-2:0], 1'b0};
        end
    end

    // Operand magnitudes at capture and sign fix-up at result load
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_mag = magnitude(dividend);
        b_mag = magnitude(divisor);
        q_fix = q_neg ? (~quo_nxt + width'(1)) : quo_nxt;
        r_fix = r_neg ? (~rem_nxt + width'(1)) : rem_nxt;
`else
        a_mag = dividend;
        b_mag = divisor;
        q_fix = quo_nxt;
        r_fix = rem_nxt;
`endif
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {width{1'b0}};
            remainder   <= {width{1'b0}};
            div_by_zero <= 1'b0;
            count       <= {cw{1'b0}};
            rem_w       <= {width{1'b0}};
            quo_w       <= {width{1'b0}};
            dvs         <= {width{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start && (divisor == {width{1'b0}})) begin
                        quotient    <= {width{1'b1}};
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        rem_w <= {width{1'b0}};
                        quo_w <= a_mag;
                        dvs   <= b_mag;
                        count <= {cw{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_neg <= dividend[width-1] ^ divisor[width-1];
                        r_neg <= dividend[width-1];
`endif
                    end
                end
                RUN: begin
                    rem_w <= rem_nxt;
                    quo_w <= quo_nxt;
                    count <= count + cw'(1);
                    if (last_iter) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
